// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: drives register hold/clear
// controls and keeps saturating cycle/stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_wnum,
    input  logic             ex_redirect,
    input  logic             mem_wait,
    input  logic             halt_req,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALT   = 2'd1,
        S_RESUME = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   load_use;
    logic   stall_case;
    logic   flush_case;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign load_use = ex_memtoreg && (ex_wnum != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_wnum)) ||
                       (id_use_rt && (id_rt == ex_wnum)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RUN;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == S_HALT);
        end
    end

    // RESUME lasts one cycle and masks halt_req so the SYSCALL can retire.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:    if (halt_req) state_nxt = S_HALT;
            S_HALT:   if (go) state_nxt = S_RESUME;
            S_RESUME: state_nxt = S_RUN;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        idex_hold  = 1'b0;
        exmem_hold = 1'b0;
        memwb_hold = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_case = 1'b0;
        flush_case = 1'b0;
        if (rst) begin
            // all controls inactive while in reset
        end else if ((state == S_HALT) || ((state == S_RUN) && halt_req)) begin
            {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold} = 5'b11111;
        end else if (mem_wait) begin
            {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold} = 5'b11111;
            stall_case = 1'b1;
        end else if (ex_redirect) begin
            // Redirect beats load-use: the ID instruction is squashed anyway.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_case = 1'b1;
        end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
            stall_case = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cycle_cnt <= sat_inc(cycle_cnt, state != S_HALT);
            stall_cnt <= sat_inc(stall_cnt, stall_case);
            flush_cnt <= sat_inc(flush_cnt, flush_case);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model predicts every cycle,
// a negedge monitor compares a wide (CNT_W=32) and a narrow (CNT_W=4) instance.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, go, id_use_rs, id_use_rt, ex_memtoreg, ex_redirect, mem_wait, halt_req;
    logic [4:0] id_rs, id_rt, ex_wnum;

    logic        pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold, ifid_flush, idex_flush, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic        pc_hold4, ifid_hold4, idex_hold4, exmem_hold4, memwb_hold4, ifid_flush4, idex_flush4, halted4;
    logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .go(go), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memtoreg(ex_memtoreg),
        .ex_wnum(ex_wnum), .ex_redirect(ex_redirect), .mem_wait(mem_wait), .halt_req(halt_req),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .exmem_hold(exmem_hold), .memwb_hold(memwb_hold), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .halted(halted), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .go(go), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memtoreg(ex_memtoreg),
        .ex_wnum(ex_wnum), .ex_redirect(ex_redirect), .mem_wait(mem_wait), .halt_req(halt_req),
        .pc_hold(pc_hold4), .ifid_hold(ifid_hold4), .idex_hold(idex_hold4),
        .exmem_hold(exmem_hold4), .memwb_hold(memwb_hold4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .halted(halted4), .cycle_cnt(cycle_cnt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        logic [6:0] ctrl;   // {pc,ifid,idex,exmem,memwb holds, ifid_flush, idex_flush}
        logic       hlt;
        longint     cyc;
        longint     stl;
        longint     fls;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain booleans for the mode, unbounded integer counters.
    bit     m_halt = 1'b0, m_resume = 1'b0;
    longint m_cyc = 0, m_stl = 0, m_fls = 0;

    function automatic logic [3:0] sat4(input longint v);
        longint t;
        t = (v > 15) ? 15 : v;
        return t[3:0];
    endfunction

    task automatic model_ctrl(output logic [6:0] c, output bit st, output bit fl);
        bit hz;
        hz = ex_memtoreg && (ex_wnum != 0) &&
             ((id_use_rs && id_rs == ex_wnum) || (id_use_rt && id_rt == ex_wnum));
        c = 7'b0; st = 0; fl = 0;
        if (rst)                                        c = 7'b0;
        else if (m_halt || (!m_resume && halt_req))     c = 7'b11111_00;
        else if (mem_wait)                      begin   c = 7'b11111_00; st = 1; end
        else if (ex_redirect)                   begin   c = 7'b00000_11; fl = 1; end
        else if (hz)                            begin   c = 7'b11000_01; st = 1; end
    endtask

    task automatic step();
        exp_t       e;
        logic [6:0] c;
        bit         st, fl;
        model_ctrl(c, st, fl);
        e.ctrl = c; e.hlt = m_halt; e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_halt = 0; m_resume = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            if (!m_halt) m_cyc++;
            if (st) m_stl++;
            if (fl) m_fls++;
            if (m_halt) begin
                if (go) begin m_halt = 0; m_resume = 1; end
            end else if (m_resume) m_resume = 0;
            else if (halt_req) m_halt = 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; go = 0; id_use_rs = 0; id_use_rt = 0; ex_memtoreg = 0;
        ex_redirect = 0; mem_wait = 0; halt_req = 0; id_rs = 0; id_rt = 0; ex_wnum = 0;
    endtask

    // Monitor: pops one prediction per presented cycle and compares both instances.
    exp_t       me;
    logic [6:0] act, act4;
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            me = sb_q.pop_front();
            vectors++;
            act  = {pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_hold, ifid_flush, idex_flush};
            act4 = {pc_hold4, ifid_hold4, idex_hold4, exmem_hold4, memwb_hold4, ifid_flush4, idex_flush4};
            if (act !== me.ctrl) begin
                miscompares++;
                $display("FAIL ctrl vec %0d: got %b expected %b", vectors, act, me.ctrl);
            end
            if (act4 !== me.ctrl) begin
                miscompares++;
                $display("FAIL ctrl4 vec %0d: got %b expected %b", vectors, act4, me.ctrl);
            end
            if (halted !== me.hlt || halted4 !== me.hlt) begin
                miscompares++;
                $display("FAIL halted vec %0d: got %b/%b expected %b", vectors, halted, halted4, me.hlt);
            end
            if (cycle_cnt !== me.cyc[31:0] || stall_cnt !== me.stl[31:0] || flush_cnt !== me.fls[31:0]) begin
                miscompares++;
                $display("FAIL counters32 vec %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", vectors,
                         cycle_cnt, stall_cnt, flush_cnt, me.cyc, me.stl, me.fls);
            end
            if (cycle_cnt4 !== sat4(me.cyc) || stall_cnt4 !== sat4(me.stl) || flush_cnt4 !== sat4(me.fls)) begin
                miscompares++;
                $display("FAIL counters4 vec %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", vectors,
                         cycle_cnt4, stall_cnt4, flush_cnt4, sat4(me.cyc), sat4(me.stl), sat4(me.fls));
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Reset state, then 20 unstalled cycles (narrow counter saturates at 15)
        repeat (20) step();

        // Load-use on rs, then the same with ex_wnum = 0 (no stall)
        ex_memtoreg = 1; ex_wnum = 8; id_rs = 8; id_use_rs = 1; step();
        idle_inputs(); step();
        ex_memtoreg = 1; ex_wnum = 0; id_rs = 0; id_use_rs = 1; step();
        // Load-use on rt
        ex_memtoreg = 1; ex_wnum = 5; id_rt = 5; id_use_rt = 1; id_use_rs = 0; step();
        idle_inputs(); step();

        // Redirect together with a load-use match
        ex_memtoreg = 1; ex_wnum = 8; id_rs = 8; id_use_rs = 1; ex_redirect = 1; step();
        idle_inputs(); step();

        // Memory wait for 3 cycles over a pending redirect, then the flush
        mem_wait = 1; ex_redirect = 1;
        repeat (3) step();
        mem_wait = 0; step();
        idle_inputs(); step();

        // Halt, resume with go held through RESUME, then back to RUN
        halt_req = 1; step();
        repeat (3) step();
        go = 1; step();
        step();
        halt_req = 0; step();
        step();
        go = 0; step();

        // go in RUN is ignored
        go = 1; repeat (2) step();
        go = 0;

        // Reset mid-HALT
        halt_req = 1; repeat (3) step();
        rst = 1; halt_req = 0; step();
        rst = 0; repeat (2) step();

        // Reset mid-stall
        mem_wait = 1; step();
        rst = 1; step();
        idle_inputs(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(199) == 0);
            go          = ($urandom_range(5) == 0);
            halt_req    = (m_halt || m_resume) ? ($urandom_range(1) == 0) : ($urandom_range(24) == 0);
            mem_wait    = ($urandom_range(5) == 0);
            ex_redirect = ($urandom_range(6) == 0);
            ex_memtoreg = ($urandom_range(2) == 0);
            id_use_rs   = ($urandom_range(1) == 0);
            id_use_rt   = ($urandom_range(1) == 0);
            id_rs       = 5'($urandom_range(7));
            id_rt       = 5'($urandom_range(7));
            ex_wnum     = 5'($urandom_range(7));
            step();
        end
        idle_inputs();

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
